// File: rtl/ram_bank.sv
// ram_bank: DEPTH x WIDTH register bank, synchronous write, combinational read (0-cycle), plus a self-timed clear sweep.
// No backpressure: while busy is high the sweep owns the write port and load/clr are dropped, not queued.
module ram_bank #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [$clog2(DEPTH)-1:0] address,
  input  logic [WIDTH-1:0]         in,
  input  logic                     clr,
  output logic [WIDTH-1:0]         out,
  output logic                     busy
);

  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   ptr, ptr_d;
  logic [WIDTH-1:0]    mem [DEPTH];

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [WIDTH-1:0]    wr_dat;

  // Single write port shared between the user path and the sweep.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    wr_en   = 1'b0;
    wr_addr = address;
    wr_dat  = in;
    case (state)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end else if (load) begin
          wr_en = 1'b1;
        end
      end
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = ptr;
        wr_dat  = '0;
        ptr_d   = ptr + 1'b1;
        if (ptr == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  assign out  = mem[address];
  assign busy = (state == CLEAR);

endmodule

// File: tb/tb_ram_bank.sv
// Directed bench for ram_bank (WIDTH=16, DEPTH=8): reset, write/hold, overwrite, clear sweep, mid-sweep reset, back-to-back clear.
module tb_ram_bank;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [2:0]  address;
  logic [15:0] in;
  logic        clr;
  logic [15:0] out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  ram_bank #(.WIDTH(16), .DEPTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .address (address),
    .in      (in),
    .clr     (clr),
    .out     (out),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_all(input logic [15:0] val);
    load = 1'b1;
    in   = val;
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      tick();
    end
    load = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1; load = 1'b0; clr = 1'b0; address = '0; in = '0;
    #5 rst_n = 1'b0;
    #2;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b want 0", busy);
    end
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      #1;
      checks++;
      if (out !== 16'h0000) begin
        errors++; $display("FAIL reset_out[%0d] got %h want 0000", i, out);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_hold;
    load = 1'b1; address = 3'd3; in = 16'hAAAA;
    tick();
    address = 3'd5; in = 16'h5555;
    #1;
    checks++;
    if (out !== 16'h0000) begin
      errors++; $display("FAIL no_bypass got %h want 0000", out);
    end
    tick();
    load = 1'b0; in = 16'hFFFF;
    tick();
    tick();
    address = 3'd3; #1;
    checks++;
    if (out !== 16'hAAAA) begin
      errors++; $display("FAIL hold_addr3 got %h want aaaa", out);
    end
    address = 3'd5; #1;
    checks++;
    if (out !== 16'h5555) begin
      errors++; $display("FAIL hold_addr5 got %h want 5555", out);
    end
    address = 3'd0; #1;
    checks++;
    if (out !== 16'h0000) begin
      errors++; $display("FAIL hold_addr0 got %h want 0000", out);
    end
  endtask

  task automatic test_overwrite;
    fill_all(16'hFFFF);
    load = 1'b1; address = 3'd7; in = 16'h1234;
    tick();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      #1;
      checks++;
      if (out !== ((i == 7) ? 16'h1234 : 16'hFFFF)) begin
        errors++;
        $display("FAIL overwrite[%0d] got %h want %h", i, out, (i == 7) ? 16'h1234 : 16'hFFFF);
      end
    end
  endtask

  task automatic test_clear_sweep;
    fill_all(16'hFFFF);
    clr = 1'b1; load = 1'b1; address = 3'd2; in = 16'hBEEF;
    tick();
    clr = 1'b0; address = 3'd4; in = 16'h0F0F;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++; $display("FAIL sweep_busy[%0d] got %b want 1", k, busy);
      end
      tick();
    end
    load = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL sweep_busy_end got %b want 0", busy);
    end
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      #1;
      checks++;
      if (out !== 16'h0000) begin
        errors++; $display("FAIL sweep_out[%0d] got %h want 0000", i, out);
      end
    end
    address = 3'd2; #1;
    checks++;
    if (out === 16'hBEEF) begin
      errors++; $display("FAIL clr_drops_load got %h want not beef", out);
    end
  endtask

  task automatic test_mid_sweep;
    fill_all(16'hFFFF);
    address = 3'd6; clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (out !== 16'hFFFF) begin
      errors++; $display("FAIL mid_sweep_start got %h want ffff", out);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (out !== ((k >= 7) ? 16'h0000 : 16'hFFFF)) begin
        errors++;
        $display("FAIL mid_sweep_edge%0d got %h want %h", k, out, (k >= 7) ? 16'h0000 : 16'hFFFF);
      end
    end
    // Second sweep interrupted by reset at sweep cycle 3.
    fill_all(16'hFFFF);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    tick();
    address = 3'd5; #1;
    checks++;
    if (busy !== 1'b1 || out !== 16'hFFFF) begin
      errors++; $display("FAIL pre_reset got busy=%b out=%h want busy=1 out=ffff", busy, out);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset_busy got %b want 0", busy);
    end
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      #1;
      checks++;
      if (out !== 16'h0000) begin
        errors++; $display("FAIL mid_reset_out[%0d] got %h want 0000", i, out);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL no_resume got busy=%b want 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    fill_all(16'hFFFF);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL b2b_first_end got %b want 0", busy);
    end
    clr = 1'b1; load = 1'b1; address = 3'd1; in = 16'h1111;
    tick();
    clr = 1'b0; load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++; $display("FAIL b2b_busy[%0d] got %b want 1", k, busy);
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL b2b_end got %b want 0", busy);
    end
    address = 3'd1; #1;
    checks++;
    if (out !== 16'h0000) begin
      errors++; $display("FAIL b2b_dropped_load got %h want 0000", out);
    end
  endtask

  initial begin
    test_reset();
    test_write_hold();
    test_overwrite();
    test_clear_sweep();
    test_mid_sweep();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_bank.md
Name: ram_bank

Overview:
- Parametrised word-addressable register bank: DEPTH words of WIDTH bits each.
- Successor to the single 16-bit load register; it is the generalised RAMn building block used by the memory hierarchy.
- Write is synchronous, gated by load. Read is combinational from address (out = mem[address]).
- Adds an asynchronous reset and a self-timed, synchronous clear-all sweep FSM with a busy flag.

Parameters:
- WIDTH, 16, data word width in bits (>= 1).
- DEPTH, 8, number of words; power of two, >= 2. ADDR_W = clog2(DEPTH) is derived as a localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  write enable; in is written to mem[address] at the rising edge.
- address  input  ADDR_W  read and write word select.
- in  input  WIDTH  write data.
- clr  input  1  request a synchronous clear of all words (sweep).
- out  output  WIDTH  combinational read data, mem[address].
- busy  output  1  high while the clear sweep is in progress.

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed):
  - all DEPTH words = 0, so out = 0.
  - state = IDLE, sweep pointer = 0, busy = 0.
  - Reset deassertion takes effect at the next rising edge.
- Read: out = mem[address], combinational, zero-cycle latency. A write to the addressed word shows on out after that edge (no same-cycle bypass).
- FSM states: IDLE, CLEAR. busy = (state == CLEAR), driven from registered state.
- IDLE:
  - load=1, clr=0: at the edge, mem[address] <= in. Other words unchanged.
  - load=0, clr=0: hold all words.
  - clr=1: at the edge, state -> CLEAR and ptr <= 0. No write occurs, even if load=1 (clr wins; the load is dropped, not queued).
- CLEAR:
  - Each edge: mem[ptr] <= 0, ptr <= ptr + 1.
  - On the edge that clears word DEPTH-1: state -> IDLE, ptr wraps to 0.
  - busy is high for exactly DEPTH cycles after the clr edge.
  - load and clr are ignored throughout, including on the final CLEAR cycle.
  - out stays live: words already swept read 0; words not yet swept read their old value.
- address out of range cannot occur (DEPTH is a power of two).
- Reset asserted mid-sweep: immediate all-zero, IDLE, busy=0. The sweep does not resume.
- Back-to-back: clr sampled on the first IDLE cycle after a sweep starts a new sweep. A load on that cycle is dropped.
- No X on out after reset, for any address.

Test Plan:
- Reset and read (WIDTH=16, DEPTH=8): rst_n=0, then 1. Sweep address 0..7 -> out=16'h0000 for every address, busy=0.
- Write/hold:
  - load=1, address=3, in=16'hAAAA, one edge; then load=1, address=5, in=16'h5555; then load=0, in=16'hFFFF for 2 edges.
  - Expect address=3 -> 16'hAAAA, address=5 -> 16'h5555, address=0 -> 16'h0000.
- Overwrite/all-ones:
  - Write 16'hFFFF to all 8 addresses, then load=1, address=7, in=16'h1234.
  - Expect address=7 -> 16'h1234 and the other seven words -> 16'hFFFF.
- Clear sweep:
  - With all words = 16'hFFFF, pulse clr=1 for one cycle with load=1, address=2, in=16'hBEEF.
  - busy=1 for exactly 8 cycles, then 0.
  - Loads issued during busy (address=4, in=16'h0F0F) have no effect.
  - At the end every address reads 16'h0000, and address=2 does not read 16'hBEEF.
- Mid-sweep observation and reset:
  - Hold address=6 during a sweep: out=16'hFFFF until the 7th sweep edge, then 16'h0000.
  - In a second sweep, assert rst_n=0 at sweep cycle 3: busy drops immediately and all words read 0 without a clock edge.
- Back-to-back clr: assert clr in the first cycle after busy falls -> a second 8-cycle busy window starts at that edge.
